cs_sequencer: RTL

//  Parametrised successor to the control-store address generator of the microprogrammed datapath.
//  - Registers the control-store address (CSAR) and selects the next address from these sources:

---
 rtl/cs_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cs_sequencer.sv
// rtl/cs_sequencer.sv - control-store address sequencer with optional return-address stack
//
// Registers the control-store address (CSAR) and picks the next address each
// unstalled cycle from: increment, jump, opcode decode, conditional jump,
// microsubroutine call or return. Optional LIFO return stack.
//
// Build option: CSSEQ_STACK_EN
//   defined   - return stack, CALL/RET/CCALL, stack level and sticky flags built
//   undefined - no stack; CALL=JUMP, RET=NEXT, CCALL=CJUMP; stack outputs tied 0
//
// Ports:
//   CSSEQ_CLOCK_50            in   system clock, rising edge
//   CSSEQ_ResetInLow_In       in   asynchronous reset, active low
//   CSSEQ_Stall_In            in   1 = hold CSAR, stack and flags
//   CSSEQ_Tipo_InBus          in   next-address type
//   CSSEQ_JumpAddress_InBus   in   jump / call target
//   CSSEQ_DecodeOp_InBus      in   opcode bits for decode mapping
//   CSSEQ_Cond_InBus          in   condition flags (bit0 = C)
//   CSSEQ_CondSel_InBus       in   flag index for conditional types
//   CSSEQ_CondInvert_In       in   invert the selected flag
//   CSSEQ_CSAddress_OutBus    out  registered CSAR
//   CSSEQ_StackLevel_OutBus   out  number of valid stack entries
//   CSSEQ_StackOverflow_Out   out  sticky: taken call while stack full
//   CSSEQ_StackUnderflow_Out  out  sticky: return while stack empty

module cs_sequencer #(
    parameter int DATAWIDTH_CSADDRESS = 11,
    parameter int DATAWIDTH_OPS       = 8,
    parameter int DATAWIDTH_CBL       = 3,
    parameter int DATAWIDTH_COND      = 4,
    parameter int DATAWIDTH_CSEL      = 2,
    parameter int STACK_DEPTH         = 4,
    parameter int DECODE_SHIFT        = 2,
    parameter int RESET_ADDRESS       = 0
) (
    input  logic                               CSSEQ_CLOCK_50,
    input  logic                               CSSEQ_ResetInLow_In,
    input  logic                               CSSEQ_Stall_In,
    input  logic [DATAWIDTH_CBL-1:0]           CSSEQ_Tipo_InBus,
    input  logic [DATAWIDTH_CSADDRESS-1:0]     CSSEQ_JumpAddress_InBus,
    input  logic [DATAWIDTH_OPS-1:0]           CSSEQ_DecodeOp_InBus,
    input  logic [DATAWIDTH_COND-1:0]          CSSEQ_Cond_InBus,
    input  logic [DATAWIDTH_CSEL-1:0]          CSSEQ_CondSel_InBus,
    input  logic                               CSSEQ_CondInvert_In,
    output logic [DATAWIDTH_CSADDRESS-1:0]     CSSEQ_CSAddress_OutBus,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   CSSEQ_StackLevel_OutBus,
    output logic                               CSSEQ_StackOverflow_Out,
    output logic                               CSSEQ_StackUnderflow_Out
);

    localparam int W    = DATAWIDTH_CSADDRESS;
    localparam int LW   = $clog2(STACK_DEPTH + 1);
    localparam int DW   = DATAWIDTH_CSADDRESS + DATAWIDTH_OPS + DECODE_SHIFT;
    localparam int CEXT = 2 ** DATAWIDTH_CSEL;

    typedef enum logic [2:0] {
        TIPO_NEXT   = 3'b000,
        TIPO_JUMP   = 3'b001,
        TIPO_DECODE = 3'b010,
        TIPO_CJUMP  = 3'b011,
        TIPO_CALL   = 3'b100,
        TIPO_RET    = 3'b101,
        TIPO_CCALL  = 3'b110,
        TIPO_RSVD   = 3'b111
    } tipo_t;

    tipo_t          tipo;
    logic [W-1:0]   csar_q, csar_d;
    logic [W-1:0]   inc_addr;
    logic [W-1:0]   dec_addr;
    logic [CEXT-1:0] cond_ext;
    logic           cond_bit;

    assign tipo     = tipo_t'(CSSEQ_Tipo_InBus);
    assign inc_addr = csar_q + W'(1);

    // Decode target: MSB forced high, opcode shifted in, excess bits dropped.
    assign dec_addr = (W'(1) << (W - 1)) | W'(DW'(CSSEQ_DecodeOp_InBus) << DECODE_SHIFT);

    // Zero-extending the flags to the full select range makes out-of-range
    // selects read as 0 without a separate compare.
    assign cond_ext = CEXT'(CSSEQ_Cond_InBus);
    assign cond_bit = cond_ext[CSSEQ_CondSel_InBus] ^ CSSEQ_CondInvert_In;

`ifdef CSSEQ_STACK_EN
    logic [W-1:0]  stack_q [STACK_DEPTH];
    logic [W-1:0]  stack_d [STACK_DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [W-1:0]  top_addr;
    logic          push_req;

    // Top of stack is the entry just below the current level.
    always_comb begin
        top_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                top_addr = stack_q[i];
            end
        end
    end
`endif

    always_comb begin
        csar_d = csar_q;
`ifdef CSSEQ_STACK_EN
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stack_d  = stack_q;
        push_req = 1'b0;
`endif
        if (!CSSEQ_Stall_In) begin
            csar_d = inc_addr;
            case (tipo)
                TIPO_JUMP:   csar_d = CSSEQ_JumpAddress_InBus;
                TIPO_DECODE: csar_d = dec_addr;
                TIPO_CJUMP: begin
                    if (cond_bit) begin
                        csar_d = CSSEQ_JumpAddress_InBus;
                    end
                end
                TIPO_CALL: begin
                    csar_d = CSSEQ_JumpAddress_InBus;
`ifdef CSSEQ_STACK_EN
                    push_req = 1'b1;
`endif
                end
                TIPO_RET: begin
`ifdef CSSEQ_STACK_EN
                    // Empty-stack return falls through to the increment.
                    if (level_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        csar_d  = top_addr;
                        level_d = level_q - LW'(1);
                    end
`endif
                end
                TIPO_CCALL: begin
                    if (cond_bit) begin
                        csar_d = CSSEQ_JumpAddress_InBus;
`ifdef CSSEQ_STACK_EN
                        push_req = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
`ifdef CSSEQ_STACK_EN
            // A push into a full stack is dropped; the jump itself still happens.
            if (push_req) begin
                if (level_q == LW'(STACK_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (level_q == LW'(i)) begin
                            stack_d[i] = inc_addr;
                        end
                    end
                    level_d = level_q + LW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge CSSEQ_CLOCK_50 or negedge CSSEQ_ResetInLow_In) begin
        if (!CSSEQ_ResetInLow_In) begin
            csar_q <= W'(RESET_ADDRESS);
        end else begin
            csar_q <= csar_d;
        end
    end

    assign CSSEQ_CSAddress_OutBus = csar_q;

`ifdef CSSEQ_STACK_EN
    always_ff @(posedge CSSEQ_CLOCK_50 or negedge CSSEQ_ResetInLow_In) begin
        if (!CSSEQ_ResetInLow_In) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign CSSEQ_StackLevel_OutBus  = level_q;
    assign CSSEQ_StackOverflow_Out  = ovf_q;
    assign CSSEQ_StackUnderflow_Out = unf_q;
`else
    assign CSSEQ_StackLevel_OutBus  = '0;
    assign CSSEQ_StackOverflow_Out  = 1'b0;
    assign CSSEQ_StackUnderflow_Out = 1'b0;
`endif

endmodule
